data_mem_lsu: RTL and testbench

- Load/store responder on the data-memory side of the core; produces the ReadData word consumed at writeback.
- Accepts one load or store request per transaction over a valid/ready handshake.
- Performs byte-enabled writes into an internal synchronous RAM, and returns sign- or zero-extended load data with a 1-cycle latency.
- Flags misaligned, out-of-range and illegal accesses.

---
 rtl/data_mem_pkg.sv | 27 ++
 rtl/data_ram.sv | 25 ++
 rtl/data_mem_lsu.sv | 135 +++++++++++++
 tb/tb_data_mem_lsu.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory load/store responder.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } lsu_state_t;

  // Byte lanes touched by an access of the given size at the given word offset.
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] m;
    case (funct3)
      F3_B, F3_BU: m = 4'b0001 << off;
      F3_H, F3_HU: m = off[1] ? 4'b1100 : 4'b0011;
      F3_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous word RAM with per-byte write enables.
// rdata only changes on a read, so it doubles as the load holding register.
module data_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane writes and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Data-memory load/store responder: one request at a time, response one
// cycle after acceptance, held until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// RESP  | response presented on rsp_*, waiting for rsp_ready
import data_mem_pkg::*;

module data_mem_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  lsu_state_t  state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        err_q;
  logic        we_q;

  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        illegal;
  logic        acc_err;
  logic [3:0]  ram_we;
  logic [31:0] wdata_rep;
  logic [31:0] ram_rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] fmt_data;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // Fault classification of the incoming request.
  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: misaligned = req_addr[0];
      F3_W:        misaligned = (req_addr[1:0] != 2'b00);
      default:     misaligned = 1'b0;
    endcase
    case (req_funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = req_we;
      default:          illegal = 1'b1;
    endcase
    out_of_range = ({2'b00, req_addr[ADDR_WIDTH-1:2]} >= DEPTH_W);
    acc_err      = misaligned || out_of_range || illegal;
  end

  // Store data replicated across lanes so the byte mask alone picks the target.
  always_comb begin
    case (req_funct3)
      F3_B:    wdata_rep = {4{req_wdata[7:0]}};
      F3_H:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata[31:0];
    endcase
    ram_we = (accept && req_we && !acc_err) ? byte_mask(req_funct3, req_addr[1:0]) : 4'b0000;
  end

  data_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rd_en (accept && !req_we && !acc_err),
    .we    (ram_we),
    .addr  (req_addr[2 +: AW]),
    .wdata (wdata_rep),
    .rdata (ram_rdata)
  );

  // Handshake FSM and capture of the per-transaction context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      off_q <= 2'b00;
      f3_q  <= 3'b000;
      err_q <= 1'b0;
      we_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RESP;
            off_q <= req_addr[1:0];
            f3_q  <= req_funct3;
            err_q <= acc_err;
            we_q  <= req_we;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane select and sign/zero extension of the held load word.
  always_comb begin
    byte_sel = ram_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (f3_q)
      F3_B:    fmt_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   fmt_data = {24'h000000, byte_sel};
      F3_H:    fmt_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   fmt_data = {16'h0000, half_sel};
      default: fmt_data = ram_rdata;
    endcase
    rsp_rdata = (rsp_valid && !err_q && !we_q) ? fmt_data : '0;
    rsp_err   = rsp_valid && err_q;
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with a byte-addressed reference model.
module tb_data_mem_lsu;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;

  bit          run = 1'b0;
  bit          exp_pending = 1'b0;
  logic [31:0] exp_rdata = '0;
  bit          exp_err = 1'b0;

  logic [7:0]  bmem [DEPTH*4];

  data_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // Reference: memory as a flat byte array, accesses as little-endian byte runs.
  function automatic void model_req(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                                    input logic [31:0] wd, output bit err, output logic [31:0] rd);
    int size;
    bit legal;
    logic [31:0] val;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
             (!we && (f3 == 3'b100 || f3 == 3'b101)));
    err   = !legal || ((addr % size) != 0) || ((addr / 4) >= DEPTH);
    rd    = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) bmem[addr + i] = wd[8*i +: 8];
    end else begin
      val = '0;
      for (int i = 0; i < size; i++) val = val | (32'(bmem[addr + i]) << (8*i));
      if (!f3[2] && size == 1) val = 32'($signed(val[7:0]));
      if (!f3[2] && size == 2) val = 32'($signed(val[15:0]));
      rd = val;
    end
  endfunction

  // Every cycle out of reset: handshake state and held response must match the model.
  always @(negedge clk) begin
    if (run && rst_n) begin
      tests++;
      if (rsp_valid !== exp_pending || req_ready !== !exp_pending) begin
        fails++;
        $display("FAIL handshake t=%0t: rsp_valid=%b req_ready=%b, want rsp_valid=%b req_ready=%b",
                 $time, rsp_valid, req_ready, exp_pending, !exp_pending);
      end
      if (exp_pending) begin
        tests++;
        if (rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
          fails++;
          $display("FAIL rsp t=%0t: rdata=%h err=%b, want rdata=%h err=%b",
                   $time, rsp_rdata, rsp_err, exp_rdata, exp_err);
        end
      end
    end
  end

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Present a request on the next edge; called #1 after a rising edge while IDLE.
  task automatic issue(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] lit_rd, input bit lit_err,
                       input string name);
    bit merr;
    logic [31:0] mrd;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    @(posedge clk); #1;
    model_req(we, addr, f3, wd, merr, mrd);
    exp_pending = 1'b1; exp_rdata = mrd; exp_err = merr;
    // Junk request while busy must be ignored.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = $urandom;
    check({name, "_lit_rdata"}, rsp_rdata === lit_rd, rsp_rdata, lit_rd);
    check({name, "_lit_err"}, rsp_err === lit_err, 32'(rsp_err), 32'(lit_err));
    check({name, "_model_pin"}, (mrd === lit_rd) && (merr == lit_err), mrd, lit_rd);
  endtask

  task automatic finish_rsp(input int stall);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_pending = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input logic [31:0] lit_rd, input bit lit_err,
                        input string name);
    issue(we, addr, f3, wd, lit_rd, lit_err, name);
    finish_rsp(0);
  endtask

  task automatic pulse_reset(input string name);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_pending = 1'b0;
    #1;
    check({name, "_async_valid"}, rsp_valid === 1'b0, 32'(rsp_valid), 32'h0);
    check({name, "_async_rdata"}, rsp_rdata === 32'h0, rsp_rdata, 32'h0);
    check({name, "_async_err"}, rsp_err === 1'b0, 32'(rsp_err), 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check({name, "_ready_after"}, req_ready === 1'b1, 32'(req_ready), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH*4; i++) bmem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", rsp_valid === 1'b0, 32'(rsp_valid), 32'h0);
    check("reset_rdata", rsp_rdata === 32'h0, rsp_rdata, 32'h0);
    check("reset_err", rsp_err === 1'b0, 32'(rsp_err), 32'h0);
    check("reset_ready", req_ready === 1'b1, 32'(req_ready), 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run = 1'b1;

    do_req(1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0, "sw_10");
    do_req(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0, "lw_10");

    do_req(1, 32'h20, 3'b010, 32'h00000000, 32'h0, 0, "sw_20");
    do_req(1, 32'h21, 3'b000, 32'h00000080, 32'h0, 0, "sb_21");
    do_req(0, 32'h20, 3'b010, 32'h0, 32'h00008000, 0, "lw_20");
    do_req(0, 32'h21, 3'b000, 32'h0, 32'hFFFFFF80, 0, "lb_21");
    do_req(0, 32'h21, 3'b100, 32'h0, 32'h00000080, 0, "lbu_21");

    do_req(1, 32'h30, 3'b010, 32'h11223344, 32'h0, 0, "sw_30");
    do_req(1, 32'h32, 3'b001, 32'h0000BEEF, 32'h0, 0, "sh_32");
    do_req(0, 32'h32, 3'b001, 32'h0, 32'hFFFFBEEF, 0, "lh_32");
    do_req(0, 32'h32, 3'b101, 32'h0, 32'h0000BEEF, 0, "lhu_32");
    do_req(0, 32'h30, 3'b010, 32'h0, 32'hBEEF3344, 0, "lw_30");
    do_req(0, 32'h30, 3'b001, 32'h0, 32'h00003344, 0, "lh_30");

    do_req(0, 32'h03, 3'b001, 32'h0, 32'h0, 1, "lh_03_mis");
    do_req(1, 32'h40, 3'b010, 32'hCAFEF00D, 32'h0, 0, "sw_40");
    do_req(1, 32'h41, 3'b010, 32'h12345678, 32'h0, 1, "sw_41_mis");
    do_req(1, 32'h42, 3'b100, 32'h000000AA, 32'h0, 1, "sbu_illegal");
    do_req(0, 32'h40, 3'b010, 32'h0, 32'hCAFEF00D, 0, "lw_40");
    do_req(0, DEPTH*4, 3'b010, 32'h0, 32'h0, 1, "lw_oor");
    do_req(1, DEPTH*4 - 4, 3'b010, 32'h01020304, 32'h0, 0, "sw_last");
    do_req(0, DEPTH*4 - 1, 3'b000, 32'h0, 32'h00000001, 0, "lb_last");
    do_req(0, 32'h10, 3'b011, 32'h0, 32'h0, 1, "f3_011");
    do_req(0, 32'h10, 3'b111, 32'h0, 32'h0, 1, "f3_111");

    do_req(1, 32'h12, 3'b000, 32'hFFFFFF5A, 32'h0, 0, "sb_12");
    issue(0, 32'h10, 3'b010, 32'h0, 32'hDE5ABEEF, 0, "lw_10_bp");
    finish_rsp(3);
    do_req(0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 0, "lb_13");

    issue(1, 32'h50, 3'b010, 32'hA5A5A5A5, 32'h0, 0, "sw_50_rst");
    pulse_reset("rst_store");
    do_req(0, 32'h50, 3'b010, 32'h0, 32'hA5A5A5A5, 0, "lw_50");
    issue(0, 32'h50, 3'b001, 32'h0, 32'hFFFFA5A5, 0, "lh_50_rst");
    pulse_reset("rst_load");
    do_req(0, 32'h52, 3'b101, 32'h0, 32'h0000A5A5, 0, "lhu_52");

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
